// File: rtl/apa102_pkg.sv
// apa102_pkg
//   Shared constants, helper function and FSM state type for the APA102
//   frame streamer.
//   - START_BYTES : zero bytes that open every frame
//   - HDR_PREFIX  : fixed top bits of each LED header byte
//   - END_FILL    : fill value of the closing bytes
//   - end_bytes() : closing byte count needed to clock data through a chain
//   - state_t     : streamer FSM encoding
package apa102_pkg;

  localparam int         START_BYTES = 4;
  localparam logic [2:0] HDR_PREFIX  = 3'b111;
  localparam logic [7:0] START_FILL  = 8'h00;
  localparam logic [7:0] END_FILL    = 8'hFF;

  // Each LED delays the clock by half a bit, so the chain needs one extra
  // SCK edge per two LEDs: one closing byte per 16 LEDs, rounded up.
  function automatic int end_bytes(input int leds);
    return (leds + 15) / 16;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_LED_HDR  = 3'd2,
    ST_LED_DATA = 3'd3,
    ST_END      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/apa102_spi_streamer_if.sv
// apa102_spi_streamer_if
//   Bundles the streamer's buffer-side and SPI-side signals.
//   - frame_valid : pulse, a new frame is readable in the buffer
//   - rd_addr     : buffer read address
//   - rd_data     : buffer read data, combinational from rd_addr
//   - sck, mosi   : mode-0 SPI link, MSB first
//   - busy        : frame on the wire
//   - frame_done  : pulse after the last end-frame bit
//   Modport master is the streamer; slave is the buffer/pin side.
interface apa102_spi_streamer_if #(
  parameter int ADDR_WIDTH = 7
);

  logic                  frame_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_data;
  logic                  sck;
  logic                  mosi;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  frame_valid, rd_data,
    output rd_addr, sck, mosi, busy, frame_done
  );

  modport slave (
    output frame_valid, rd_data,
    input  rd_addr, sck, mosi, busy, frame_done
  );

endinterface

// File: rtl/spi_byte_tx.sv
// spi_byte_tx
//   Mode-0 SPI byte shifter with a clock divider. Each bit presents MOSI,
//   holds SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - i_clk, i_rst_n : clock, synchronous active-low reset
//   - i_load, i_byte : load a byte; first bit appears the next cycle
//   - o_ready        : idle, or last cycle of bit 0 (gapless reload point)
//   - o_sck, o_mosi  : SPI outputs, both low while idle
module spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_sck,
  output logic       o_mosi
);

  localparam int               DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             sck_q;
  logic             half_end;

  assign half_end = (div_cnt == DIV_LAST);
  assign o_ready  = !active || (sck_q && half_end && (bit_cnt == 3'd0));
  assign o_sck    = sck_q;
  assign o_mosi   = active & shreg[7];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (i_load) begin
      active  <= 1'b1;
      shreg   <= i_byte;
      bit_cnt <= 3'd7;
      div_cnt <= '0;
      sck_q   <= 1'b0;
    end else if (active) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        sck_q   <= ~sck_q;
        // End of the high half closes the bit: advance or go idle.
        if (sck_q) begin
          if (bit_cnt == 3'd0) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/apa102_spi_streamer.sv
// apa102_spi_streamer
//   Streams one APA102 frame per buffer frame: 4 zero bytes, then per LED a
//   {111,BRIGHTNESS} header followed by B, G, R read from the buffer, then
//   end_bytes(LEDS) bytes of 0xFF. Requests arriving mid-frame are held in a
//   single pending flag and start the next frame straight after DONE.
//   - i_clk, i_rst_n : clock, synchronous active-low reset
//   - bus (master)   : frame_valid in, rd_addr/rd_data buffer read port,
//                      sck/mosi SPI out, busy and frame_done status
module apa102_spi_streamer #(
  parameter int         LEDS       = 30,
  parameter int         ADDR_WIDTH = $clog2(LEDS * 3),
  parameter int         CLK_DIV    = 2,
  parameter logic [4:0] BRIGHTNESS = 5'd31
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  apa102_spi_streamer_if.master bus
);

  import apa102_pkg::*;

  localparam int END_BYTES = end_bytes(LEDS);
  localparam int LED_W     = $clog2(LEDS);
  localparam int CNT_W     = $clog2(START_BYTES + END_BYTES);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_BYTES - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_BYTES - 1);
  localparam logic [LED_W-1:0] LED_LAST   = LED_W'(LEDS - 1);
  localparam logic [7:0]       HDR_BYTE   = {HDR_PREFIX, BRIGHTNESS};

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic [1:0]            sub_q, sub_d;
  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] led_base;

  logic       load;
  logic       use_data;
  logic [7:0] fill_byte;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       busy;

  assign busy = state_q inside {ST_START, ST_LED_HDR, ST_LED_DATA, ST_END};

  // Next-byte selection. This block never reads rd_data, so the external
  // combinational rd_addr -> rd_data path cannot close a loop through it.
  // NOTE: every variable gets a default before the case so no path through
  // the block leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    led_d      = led_q;
    sub_d      = sub_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    load       = 1'b0;
    use_data   = 1'b0;
    fill_byte  = START_FILL;
    led_base   = ADDR_WIDTH'(led_q) * ADDR_WIDTH'(3);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Loading here puts the first start bit on MOSI as busy rises.
        if (bus.frame_valid || pending_q) begin
          state_d    = ST_START;
          byte_cnt_d = '0;
          pending_d  = 1'b0;
          load       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (tx_ready) begin
          load = 1'b1;
          if (byte_cnt_q == START_LAST) begin
            state_d   = ST_LED_HDR;
            led_d     = '0;
            fill_byte = HDR_BYTE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      ST_LED_HDR: begin
        if (tx_ready) begin
          load     = 1'b1;
          use_data = 1'b1;
          state_d  = ST_LED_DATA;
          sub_d    = 2'd0;
          addr_d   = led_base + ADDR_WIDTH'(2);
        end
      end

      ST_LED_DATA: begin
        if (tx_ready) begin
          load = 1'b1;
          if (sub_q == 2'd0) begin
            use_data = 1'b1;
            sub_d    = 2'd1;
            addr_d   = led_base + ADDR_WIDTH'(1);
          end else if (sub_q == 2'd1) begin
            use_data = 1'b1;
            sub_d    = 2'd2;
            addr_d   = led_base;
          end else if (led_q == LED_LAST) begin
            state_d    = ST_END;
            byte_cnt_d = '0;
            fill_byte  = END_FILL;
          end else begin
            state_d   = ST_LED_HDR;
            led_d     = led_q + 1'b1;
            fill_byte = HDR_BYTE;
          end
        end
      end

      ST_END: begin
        if (tx_ready) begin
          if (byte_cnt_q == END_LAST) begin
            state_d = ST_DONE;
          end else begin
            load       = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
            fill_byte  = END_FILL;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A pulse during DONE is consumed by the case above, not parked here.
    if (bus.frame_valid && busy) begin
      pending_d = 1'b1;
    end

    if (!i_rst_n) begin
      load   = 1'b0;
      addr_d = '0;
    end
  end

  assign bus.rd_addr = addr_d;
  assign tx_byte     = use_data ? bus.rd_data : fill_byte;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      led_q      <= '0;
      sub_q      <= '0;
      pending_q  <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      led_q      <= led_d;
      sub_q      <= sub_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
    end
  end

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load),
    .i_byte  (tx_byte),
    .o_ready (tx_ready),
    .o_sck   (bus.sck),
    .o_mosi  (bus.mosi)
  );

  assign bus.busy       = busy;
  assign bus.frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_apa102_spi_streamer.sv
// tb_apa102_spi_streamer
//   dut_a: 2 LEDs, CLK_DIV=1, BRIGHTNESS=3 (byte stream, frame length,
//          address order, mid-frame reset, idle quietness).
//   dut_b: 30 LEDs, CLK_DIV=3 (SCK/MOSI timing, queued back-to-back frames).
//   Expected bytes are queued when a frame is requested and popped as the
//   monitor assembles bytes on SCK rising edges.
module tb_apa102_spi_streamer;

  localparam int A_LEDS      = 2;
  localparam int A_AW        = 3;
  localparam int A_FRAME_CYC = 13 * 16 * 1;    // (4+8+1) bytes, CLK_DIV=1
  localparam int B_LEDS      = 30;
  localparam int B_AW        = 7;
  localparam int B_BYTES     = 4 + 4 * 30 + 2;
  localparam int B_FRAME_CYC = B_BYTES * 16 * 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  apa102_spi_streamer_if #(.ADDR_WIDTH(A_AW)) if_a ();
  apa102_spi_streamer_if #(.ADDR_WIDTH(B_AW)) if_b ();

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [128];

  assign if_a.rd_data = mem_a[if_a.rd_addr];
  assign if_b.rd_data = mem_b[if_b.rd_addr];

  apa102_spi_streamer #(
    .LEDS(A_LEDS), .ADDR_WIDTH(A_AW), .CLK_DIV(1), .BRIGHTNESS(5'd3)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .bus(if_a)
  );

  apa102_spi_streamer #(
    .LEDS(B_LEDS), .ADDR_WIDTH(B_AW), .CLK_DIV(3), .BRIGHTNESS(5'd31)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .bus(if_b)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  // Monitor state
  int              cyc = 0;
  int              a_bits = 0, a_bytes = 0, a_done_cnt = 0, a_glitch = 0;
  int              a_rise_cyc = 0, a_done_cyc = 0;
  logic [7:0]      a_sh = '0;
  logic            a_sck_q = 1'b0, a_busy_q = 1'b0;
  logic [A_AW-1:0] a_addr_q = '0;
  int              a_addr_log [$];

  int              b_bits = 0, b_bytes = 0, b_done_cnt = 0, b_glitch = 0;
  int              b_rise_n = 0, b_done_n = 0, b_busy_low = 0;
  int              b_rise [2];
  int              b_done_c [2];
  int              b_low = 0, b_high = 0;
  logic            b_win = 1'b0, b_mosi_ref = 1'b0, b_mosi_chg = 1'b0;
  logic [7:0]      b_sh = '0;
  logic            b_sck_q = 1'b0, b_busy_q = 1'b0;

  always @(negedge clk) begin
    cyc++;

    // ---------------- dut_a ----------------
    if (if_a.busy !== 1'b1) begin
      a_bits = 0;
    end else if (if_a.sck === 1'b1 && a_sck_q !== 1'b1) begin
      a_sh = {a_sh[6:0], if_a.mosi};
      a_bits++;
      if (a_bits == 8) begin
        a_bits = 0;
        a_bytes++;
        if (exp_a.size() == 0) check("a_unexpected_byte", {24'h0, a_sh}, 32'h100);
        else check("a_byte", {24'h0, a_sh}, {24'h0, exp_a.pop_front()});
      end
    end
    a_sck_q = if_a.sck;
    if (if_a.busy === 1'b1 && a_busy_q !== 1'b1) a_rise_cyc = cyc;
    a_busy_q = if_a.busy;
    if (if_a.frame_done === 1'b1) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    if (if_a.busy === 1'b1 && if_a.rd_addr !== a_addr_q) a_addr_log.push_back(int'(if_a.rd_addr));
    a_addr_q = if_a.rd_addr;
    if (if_a.busy === 1'b0 && (if_a.sck !== 1'b0 || if_a.mosi !== 1'b0)) a_glitch++;

    // ---------------- dut_b ----------------
    if (if_b.sck === 1'b0 && b_sck_q === 1'b1) begin
      check("b_high_run", b_high, 3);
      check("b_mosi_stable", {31'h0, b_mosi_chg}, 0);
      b_high = 0;
    end
    if (if_b.busy !== 1'b1) begin
      b_bits = 0;
    end else if (if_b.sck === 1'b1 && b_sck_q !== 1'b1) begin
      check("b_low_run", b_low, 3);
      b_low = 0;
      b_sh = {b_sh[6:0], if_b.mosi};
      b_bits++;
      if (b_bits == 8) begin
        b_bits = 0;
        b_bytes++;
        if (exp_b.size() == 0) check("b_unexpected_byte", {24'h0, b_sh}, 32'h100);
        else check("b_byte", {24'h0, b_sh}, {24'h0, exp_b.pop_front()});
      end
    end
    if (if_b.busy === 1'b1 && if_b.sck === 1'b0) begin
      b_low++;
      if (b_low == 1) begin
        b_mosi_ref = if_b.mosi;
        b_mosi_chg = 1'b0;
      end else if (if_b.mosi !== b_mosi_ref) begin
        b_mosi_chg = 1'b1;
      end
    end
    if (if_b.sck === 1'b1) begin
      b_high++;
      if (if_b.mosi !== b_mosi_ref) b_mosi_chg = 1'b1;
    end
    b_sck_q = if_b.sck;
    if (if_b.busy === 1'b1 && b_busy_q !== 1'b1) begin
      b_win = 1'b1;
      if (b_rise_n < 2) b_rise[b_rise_n] = cyc;
      b_rise_n++;
    end
    b_busy_q = if_b.busy;
    if (if_b.frame_done === 1'b1) begin
      if (b_done_n < 2) b_done_c[b_done_n] = cyc;
      b_done_n++;
      b_done_cnt++;
    end
    if (b_win && if_b.busy === 1'b0 && b_done_cnt < 2) b_busy_low++;
    if (if_b.busy === 1'b0 && (if_b.sck !== 1'b0 || if_b.mosi !== 1'b0)) b_glitch++;
  end

  task automatic push_frame_a();
    for (int i = 0; i < 4; i++) exp_a.push_back(8'h00);
    for (int n = 0; n < A_LEDS; n++) begin
      exp_a.push_back(8'hE3);
      exp_a.push_back(mem_a[3*n+2]);
      exp_a.push_back(mem_a[3*n+1]);
      exp_a.push_back(mem_a[3*n]);
    end
    exp_a.push_back(8'hFF);
  endtask

  task automatic push_frame_b();
    for (int i = 0; i < 4; i++) exp_b.push_back(8'h00);
    for (int n = 0; n < B_LEDS; n++) begin
      exp_b.push_back(8'hFF);
      exp_b.push_back(mem_b[3*n+2]);
      exp_b.push_back(mem_b[3*n+1]);
      exp_b.push_back(mem_b[3*n]);
    end
    for (int i = 0; i < 2; i++) exp_b.push_back(8'hFF);
  endtask

  task automatic pulse_a();
    if_a.frame_valid = 1'b1;
    @(negedge clk);
    if_a.frame_valid = 1'b0;
  endtask

  task automatic pulse_b();
    if_b.frame_valid = 1'b1;
    @(negedge clk);
    if_b.frame_valid = 1'b0;
  endtask

  int exp_addr [6] = '{2, 1, 0, 5, 4, 3};
  int base;

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    if_a.frame_valid = 1'b0;
    if_b.frame_valid = 1'b0;
    mem_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
    for (int i = 0; i < 128; i++) mem_b[i] = 8'(i * 37 + 5);

    repeat (3) @(negedge clk);
    check("a_rst_sck",  {31'h0, if_a.sck}, 0);
    check("a_rst_mosi", {31'h0, if_a.mosi}, 0);
    check("a_rst_busy", {31'h0, if_a.busy}, 0);
    check("a_rst_done", {31'h0, if_a.frame_done}, 0);
    check("a_rst_addr", {29'h0, if_a.rd_addr}, 0);
    check("b_rst_sck",  {31'h0, if_b.sck}, 0);
    check("b_rst_busy", {31'h0, if_b.busy}, 0);
    check("b_rst_addr", {25'h0, if_b.rd_addr}, 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Idle with no request
    repeat (30) @(negedge clk);
    check("a_idle_glitch", a_glitch, 0);
    check("b_idle_glitch", b_glitch, 0);
    check("a_idle_addr", {29'h0, if_a.rd_addr}, 0);
    check("a_idle_busy", {31'h0, if_a.busy}, 0);

    // dut_a: one full frame
    push_frame_a();
    pulse_a();
    for (int i = 0; i < 1000 && a_done_cnt < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("a_done_count", a_done_cnt, 1);
    check("a_frame_cycles", a_done_cyc - a_rise_cyc, A_FRAME_CYC);
    check("a_byte_count", a_bytes, 13);
    check("a_sb_empty", exp_a.size(), 0);
    check("a_addr_log_len", a_addr_log.size(), 6);
    for (int i = 0; i < 6 && i < a_addr_log.size(); i++) check("a_addr_seq", a_addr_log[i], exp_addr[i]);

    // dut_a: idle after a frame stays quiet with the address held
    repeat (40) @(negedge clk);
    check("a_post_idle_glitch", a_glitch, 0);
    check("a_post_idle_addr", {29'h0, if_a.rd_addr}, 3);
    check("a_post_idle_done", a_done_cnt, 1);

    // dut_a: reset during LED_DATA with SCK high
    base = a_bytes;
    push_frame_a();
    pulse_a();
    for (int i = 0; i < 1000 && !(a_bytes == base + 6 && if_a.sck === 1'b1); i++) @(negedge clk);
    check("a_abort_point", {31'h0, if_a.sck}, 1);
    rst_a_n = 1'b0;
    @(negedge clk);
    check("a_abort_sck",  {31'h0, if_a.sck}, 0);
    check("a_abort_mosi", {31'h0, if_a.mosi}, 0);
    check("a_abort_busy", {31'h0, if_a.busy}, 0);
    check("a_abort_addr", {29'h0, if_a.rd_addr}, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    exp_a.delete();
    repeat (20) @(negedge clk);
    check("a_abort_no_done", a_done_cnt, 1);
    check("a_abort_glitch", a_glitch, 0);
    push_frame_a();
    pulse_a();
    for (int i = 0; i < 1000 && a_done_cnt < 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("a_restart_done", a_done_cnt, 2);
    check("a_restart_cycles", a_done_cyc - a_rise_cyc, A_FRAME_CYC);
    check("a_restart_sb_empty", exp_a.size(), 0);

    // dut_b: two requests during a frame collapse into one queued frame
    push_frame_b();
    pulse_b();
    for (int i = 0; i < 8000 && b_bytes < 50; i++) @(negedge clk);
    check("b_reached_byte50", b_bytes, 50);
    push_frame_b();
    pulse_b();
    repeat (4) @(negedge clk);
    pulse_b();
    for (int i = 0; i < 20000 && b_done_cnt < 2; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    check("b_done_count", b_done_cnt, 2);
    check("b_byte_count", b_bytes, 2 * B_BYTES);
    check("b_sb_empty", exp_b.size(), 0);
    check("b_frame0_cycles", b_done_c[0] - b_rise[0], B_FRAME_CYC);
    check("b_frame1_cycles", b_done_c[1] - b_rise[1], B_FRAME_CYC);
    check("b_back_to_back", b_rise[1] - b_done_c[0], 1);
    check("b_busy_low_cycles", b_busy_low, 1);
    check("b_glitch", b_glitch, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apa102_spi_streamer.md
Name: apa102_spi_streamer

Overview:
Downstream consumer of the LED frame double buffer. When the buffer flags a new read frame, this block walks the read side of the buffer one byte at a time and streams a complete APA102 frame over a mode-0 SPI link: start frame, per-LED frames and end frame. It exposes a busy flag so the frame producer holds off swapping while a frame is on the wire.

Parameters:
LEDS, 30, number of LEDs; the buffer holds LEDS*3 bytes, R,G,B per LED at addresses 3n, 3n+1, 3n+2
ADDR_WIDTH, $clog2(LEDS*3), buffer read address width
CLK_DIV, 2, i_clk cycles per SCK half-period (>=1)
BRIGHTNESS, 5'd31, global 5-bit brightness field in every LED header

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_frame_valid  in  1  one-cycle pulse: a new frame is readable (from buffer o_read_frame_valid)
o_rd_addr  out  ADDR_WIDTH  buffer read address
i_rd_data  in  8  buffer read data, combinational from o_rd_addr (same cycle)
o_sck  out  1  SPI clock, idle low
o_mosi  out  1  SPI data, MSB first
o_busy  out  1  frame transmission in progress
o_frame_done  out  1  one-cycle pulse when the last end-frame bit completes

Behaviour:
- Reset: clock i_clk; reset i_rst_n, synchronous, active-low. In reset o_sck=0, o_mosi=0, o_busy=0, o_frame_done=0, o_rd_addr=0; FSM to IDLE; pending flag cleared. Reset mid-frame aborts on the next edge with no further SCK edges.
- Frame layout, TOTAL_BYTES = 4 + 4*LEDS + END_BYTES, END_BYTES = (LEDS+15)/16 (2 for LEDS=30):
  - START: 4 bytes 0x00.
  - LED n = 0..LEDS-1: header {3'b111, BRIGHTNESS}, then B (addr 3n+2), G (addr 3n+1), R (addr 3n).
  - END: END_BYTES bytes 0xFF.
- Buffer read: o_rd_addr is driven to the required address in the cycle the byte is loaded into the shift register. i_rd_data is sampled in that same cycle. o_rd_addr holds its last value otherwise.
- SPI timing, mode 0:
  - Each bit: MOSI valid at phase start, SCK low for CLK_DIV cycles, then high for CLK_DIV cycles. One bit = 2*CLK_DIV cycles.
  - Bytes are back-to-back with no gap.
  - Frame length = TOTAL_BYTES*16*CLK_DIV cycles (4032 for defaults).
- FSM states: IDLE, START, LED_HDR, LED_DATA (B/G/R sub-index 0..2), END, DONE.
  - IDLE -> START on i_frame_valid. o_busy=1 from the next cycle; first SCK rise CLK_DIV cycles after that.
  - START -> LED_HDR after 4 bytes.
  - LED_HDR -> LED_DATA after 1 byte.
  - LED_DATA -> LED_HDR after 3 bytes (next LED), or -> END when LED LEDS-1 completes.
  - END -> DONE after END_BYTES bytes.
  - DONE lasts 1 cycle: o_frame_done=1, o_busy=0, o_sck=0, o_mosi=0. Then -> START if pending is set (clearing pending), else -> IDLE.
- Frame request while busy (including a DONE-cycle pulse): set the pending flag. Multiple pulses collapse to one pending frame. The upstream producer must not swap while o_busy=1; the block does not check this.
- Counters: LED index $clog2(LEDS) bits, bit counter 3 bits, divider $clog2(CLK_DIV)+1 bits; no wrap beyond terminal counts.

Decomposition:
- Package apa102_pkg:
  - START_BYTES=4, HDR_PREFIX=3'b111, END_FILL=8'hFF.
  - Function end_bytes(leds).
  - State enum typedef.
- Sub-module spi_byte_tx: divider plus 8-bit shifter. Ports i_load/i_byte/o_ready/o_sck/o_mosi. o_ready is high in the last cycle of bit 0 so the next load is gapless.
- Top keeps FSM, byte/LED counters, address generation and pending logic.

Test Plan:
- LEDS=2, CLK_DIV=1, buffer {R0=0x11, G0=0x22, B0=0x33, R1=0x44, G1=0x55, B1=0x66}, one i_frame_valid pulse -> MOSI bytes sampled on SCK rise = 00 00 00 00 FF 33 22 11 FF 66 55 44 FF; 13*16=208 cycles from busy rise to o_frame_done; exactly one done pulse.
- BRIGHTNESS=5'd3 -> every header byte 0xE3; o_rd_addr sequence 2,1,0,5,4,3 at the byte-load cycles.
- Defaults, frame request mid-frame (byte 50) plus a second pulse -> exactly two frames sent back-to-back; busy low only during the single DONE cycle.
- Reset asserted mid-LED_DATA with SCK high -> next cycle o_sck=0, o_mosi=0, o_busy=0; no o_frame_done; a new request restarts from the start frame.
- CLK_DIV=3 -> SCK high/low 3 cycles each; MOSI stable from 3 cycles before each rising edge through the following fall.
- Idle with no request -> o_sck never toggles; o_rd_addr constant.
